// File: rtl/mqc_pkg.sv
// Framing constants, trailer layout and receiver FSM states shared by the capture-buffer
// write and read sides.
package mqc_pkg;

  localparam int unsigned pBLK_LEN = 1024;
  localparam int unsigned pCH_NUM  = 17;
  localparam logic [15:0] pMAGIC   = 16'hAFA;

  localparam int unsigned CH_W   = 5;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned SMP_W  = 12;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(pCH_NUM - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(pBLK_LEN - 1);

  // Trailer word: PAD [31:21], CH [20:16], MAGIC [15:0]
  typedef struct packed {
    logic [10:0]     pad;
    logic [CH_W-1:0] ch;
    logic [15:0]     magic;
  } trailer_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HUNT = 2'd1,
    S_LOCK = 2'd2,
    S_IQ   = 2'd3
  } state_t;

endpackage

// File: rtl/mqc_trailer_chk.sv
// Combinational trailer decode: trailer form, channel field and channel range.
module mqc_trailer_chk
  import mqc_pkg::*;
(
  input  logic [31:0]     word,
  output logic            is_trailer_c,
  output logic [CH_W-1:0] ch_c,
  output logic            ch_ok_c
);

  trailer_t trl;

  assign trl          = trailer_t'(word);
  assign is_trailer_c = (trl.pad == '0) && (trl.magic == pMAGIC);
  assign ch_c         = trl.ch;
  assign ch_ok_c      = (trl.ch <= CH_LAST);

endmodule

// File: rtl/mqc_r_deframer.sv
// DSP-side capture-buffer receiver: recovers tagged service-channel blocks with trailer
// lock tracking, or unpacks IQ captures into 12-bit re/im samples.
module mqc_r_deframer
  import mqc_pkg::*;
#(
  parameter int unsigned pDAT_W  = 32,
  parameter int unsigned pIQ_NUM = 163800
) (
  input  logic                iclk_dsp,
  input  logic                ireset,
  input  logic                istart,
  input  logic                imode_iq,
  input  logic                ivalid,
  input  logic [pDAT_W/2-1:0] idata_0,
  input  logic [pDAT_W/2-1:0] idata_1,
  output logic                ovalid,
  output logic [CH_W-1:0]     ochan,
  output logic [IDX_W-1:0]    oidx,
  output logic [pDAT_W-1:0]   odata,
  output logic                oiq_valid,
  output logic [SMP_W-1:0]    ore,
  output logic [SMP_W-1:0]    oim,
  output logic                olocked,
  output logic                oblk_ok,
  output logic                oblk_err,
  output logic                oframe_done,
  output logic [15:0]         oerr_cnt
);

  localparam int unsigned HALF_W = pDAT_W / 2;
  localparam int unsigned CNT_W  = $clog2(pIQ_NUM + 1);
  localparam logic [CNT_W-1:0] IQ_LAST = CNT_W'(pIQ_NUM - 1);

  logic [pDAT_W-1:0] word;
  logic              is_trailer;
  logic [CH_W-1:0]   trl_ch;
  logic              trl_ch_ok;

  state_t            state, state_nxt, st_e;
  logic [IDX_W-1:0]  widx, widx_nxt, widx_e;
  logic [CH_W-1:0]   exp_ch, exp_nxt, exp_e;
  logic [CNT_W-1:0]  iqcnt, iq_nxt, iq_e;

  logic              valid_nxt, iq_valid_nxt, ok_nxt, done_nxt, err_hit, locked_nxt;
  logic [CH_W-1:0]   chan_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [pDAT_W-1:0] data_nxt;
  logic [SMP_W-1:0]  re_nxt, im_nxt;
  logic [15:0]       cnt_nxt;
  logic              sign_ok;

  assign word = {idata_0, idata_1};

  // Each 12-bit sample must be sign-extended through the top of its half
  assign sign_ok = ((&word[pDAT_W-1:HALF_W+SMP_W-1]) || (~|word[pDAT_W-1:HALF_W+SMP_W-1])) &&
                   ((&word[HALF_W-1:SMP_W-1])       || (~|word[HALF_W-1:SMP_W-1]));

  mqc_trailer_chk u_trailer_chk (
    .word         (word),
    .is_trailer_c (is_trailer),
    .ch_c         (trl_ch),
    .ch_ok_c      (trl_ch_ok)
  );

  // Next-state and output decode; istart re-bases the readout before a same-cycle word
  always_comb begin
    st_e   = state;
    widx_e = widx;
    exp_e  = exp_ch;
    iq_e   = iqcnt;
    if (istart) begin
      st_e   = imode_iq ? S_IQ : S_LOCK;
      widx_e = '0;
      exp_e  = '0;
      iq_e   = '0;
    end

    state_nxt    = st_e;
    widx_nxt     = widx_e;
    exp_nxt      = exp_e;
    iq_nxt       = iq_e;
    valid_nxt    = 1'b0;
    iq_valid_nxt = 1'b0;
    ok_nxt       = 1'b0;
    done_nxt     = 1'b0;
    err_hit      = 1'b0;
    chan_nxt     = ochan;
    idx_nxt      = oidx;
    data_nxt     = odata;
    re_nxt       = ore;
    im_nxt       = oim;

    if (ivalid) begin
      case (st_e)
        S_LOCK: begin
          if (widx_e != IDX_LAST) begin
            valid_nxt = 1'b1;
            chan_nxt  = exp_e;
            idx_nxt   = widx_e;
            data_nxt  = word;
            widx_nxt  = widx_e + 1'b1;
          end else begin
            widx_nxt = '0;
            if (is_trailer && (trl_ch == exp_e)) begin
              ok_nxt   = 1'b1;
              done_nxt = (exp_e == CH_LAST);
              exp_nxt  = (exp_e == CH_LAST) ? '0 : exp_e + 1'b1;
            end else begin
              err_hit   = 1'b1;
              state_nxt = S_HUNT;
            end
          end
        end
        S_HUNT: begin
          if (is_trailer && trl_ch_ok) begin
            exp_nxt   = (trl_ch == CH_LAST) ? '0 : trl_ch + 1'b1;
            widx_nxt  = '0;
            state_nxt = S_LOCK;
          end
        end
        S_IQ: begin
          iq_valid_nxt = 1'b1;
          re_nxt       = word[HALF_W+SMP_W-1:HALF_W];
          im_nxt       = word[SMP_W-1:0];
          err_hit      = !sign_ok;
          iq_nxt       = iq_e + 1'b1;
          if (iq_e == IQ_LAST) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: ;
      endcase
    end

    cnt_nxt = oerr_cnt;
    if (err_hit && (oerr_cnt != '1)) cnt_nxt = oerr_cnt + 1'b1;
    locked_nxt = (state_nxt == S_LOCK);
  end

  // State and registered outputs
  always_ff @(posedge iclk_dsp or negedge ireset) begin
    if (!ireset) begin
      state       <= S_IDLE;
      widx        <= '0;
      exp_ch      <= '0;
      iqcnt       <= '0;
      ovalid      <= 1'b0;
      ochan       <= '0;
      oidx        <= '0;
      odata       <= '0;
      oiq_valid   <= 1'b0;
      ore         <= '0;
      oim         <= '0;
      olocked     <= 1'b0;
      oblk_ok     <= 1'b0;
      oblk_err    <= 1'b0;
      oframe_done <= 1'b0;
      oerr_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      widx        <= widx_nxt;
      exp_ch      <= exp_nxt;
      iqcnt       <= iq_nxt;
      ovalid      <= valid_nxt;
      ochan       <= chan_nxt;
      oidx        <= idx_nxt;
      odata       <= data_nxt;
      oiq_valid   <= iq_valid_nxt;
      ore         <= re_nxt;
      oim         <= im_nxt;
      olocked     <= locked_nxt;
      oblk_ok     <= ok_nxt;
      oblk_err    <= err_hit;
      oframe_done <= done_nxt;
      oerr_cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mqc_r_deframer.sv
// Directed-random bench for mqc_r_deframer with expectations built from the framing rules.
`timescale 1ns/1ps
module tb_mqc_r_deframer;

  localparam int unsigned BL  = 1024;
  localparam int unsigned NCH = 17;
  localparam int unsigned IQN = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        istart = 1'b0, imode_iq = 1'b0, ivalid = 1'b0;
  logic [15:0] d0 = '0, d1 = '0;
  logic        ovalid, oiq_valid, olocked, oblk_ok, oblk_err, oframe_done;
  logic [4:0]  ochan;
  logic [9:0]  oidx;
  logic [31:0] odata;
  logic [11:0] ore, oim;
  logic [15:0] oerr_cnt;

  mqc_r_deframer #(.pDAT_W(32), .pIQ_NUM(IQN)) dut (
    .iclk_dsp(clk), .ireset(rst_n), .istart(istart), .imode_iq(imode_iq), .ivalid(ivalid),
    .idata_0(d0), .idata_1(d1), .ovalid(ovalid), .ochan(ochan), .oidx(oidx), .odata(odata),
    .oiq_valid(oiq_valid), .ore(ore), .oim(oim), .olocked(olocked), .oblk_ok(oblk_ok),
    .oblk_err(oblk_err), .oframe_done(oframe_done), .oerr_cnt(oerr_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, gap_pct = 0;
  int n_ok, n_err, n_fd, fd_at_ok, fd_at_iq;
  logic [46:0] q_dat[$], eq[$], ref_q[$];
  logic [23:0] q_iq[$], eiq[$];
  int          q_ep[$], eep[$];
  logic [31:0] ws[$];
  logic [31:0] fw[NCH*BL];

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (ovalid) q_dat.push_back({ochan, oidx, odata});
    if (oiq_valid) q_iq.push_back({ore, oim});
    if (oblk_ok) n_ok++;
    if (oblk_err) begin n_err++; q_ep.push_back(q_iq.size()); end
    if (oframe_done) begin n_fd++; fd_at_ok = n_ok; fd_at_iq = q_iq.size(); end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    q_dat.delete(); q_iq.delete(); q_ep.delete(); eq.delete(); eiq.delete(); eep.delete();
    ws.delete(); n_ok = 0; n_err = 0; n_fd = 0; fd_at_ok = -1; fd_at_iq = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; ivalid = 1'b0; istart = 1'b0; end
  endtask

  task automatic send(input logic [31:0] w, input logic st, input logic md);
    while (gap_pct != 0 && int'($urandom_range(99)) < gap_pct) begin
      @(posedge clk); #1;
      ivalid = 1'b0; istart = 1'b0; {d0, d1} = $urandom; imode_iq = 1'($urandom);
    end
    @(posedge clk); #1;
    ivalid = 1'b1; istart = st; imode_iq = md; {d0, d1} = w;
  endtask

  // Stream ws; optionally raise istart with the first word
  task automatic play(input logic md, input logic st);
    for (int k = 0; k < ws.size(); k++)
      send(ws[k], st && (k == 0), (k == 0) ? md : 1'($urandom));
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_len"}, 64'(q_dat.size()), 64'(eq.size()));
    for (int k = 0; k < eq.size() && k < q_dat.size(); k++) chk(tag, q_dat[k], eq[k]);
  endtask

  function automatic logic [31:0] rnd_dat();
    logic [31:0] w;
    w = $urandom;
    if (w[31:21] == 11'd0) w[31] = 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] trl(input int ch);
    return {11'd0, 5'(ch), 16'h0AFA};
  endfunction

  function automatic bit in_rng(input logic [15:0] h);
    int s;
    s = int'($signed(h));
    return (s >= -2048) && (s <= 2047);
  endfunction

  initial begin
    int exp_errs;
    logic [31:0] w;
    for (int k = 0; k < NCH*BL; k++)
      fw[k] = ((k % BL) == BL-1) ? trl(k / BL) : rnd_dat();

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_ovalid", ovalid, 0);       chk("rst_oiq_valid", oiq_valid, 0);
    chk("rst_olocked", olocked, 0);     chk("rst_pulses", {oblk_ok, oblk_err, oframe_done}, 0);
    chk("rst_oerr_cnt", oerr_cnt, 0);   chk("rst_data", {ochan, oidx, odata, ore, oim}, 0);
    rst_n = 1'b1;
    idle(2);

    // Full gapless frame, istart together with the first word
    clr();
    for (int k = 0; k < NCH*BL; k++) begin
      ws.push_back(fw[k]);
      if ((k % BL) != BL-1) eq.push_back({5'(k / BL), 10'(k % BL), fw[k]});
    end
    play(1'b0, 1'b1);
    idle(3);
    cmp_q("t1_dat");
    chk("t1_ok", n_ok, NCH);  chk("t1_fd", n_fd, 1);  chk("t1_fd_at", fd_at_ok, NCH);
    chk("t1_err", n_err, 0);  chk("t1_cnt", oerr_cnt, 0);  chk("t1_lock", olocked, 1);
    ref_q = q_dat;

    // Same frame with random ivalid gaps, istart on its own cycle
    clr();
    @(posedge clk); #1; istart = 1'b1; ivalid = 1'b0; imode_iq = 1'b0;
    gap_pct = 30;
    for (int k = 0; k < NCH*BL; k++) send(fw[k], 1'b0, 1'($urandom));
    gap_pct = 0;
    idle(3);
    eq = ref_q;
    cmp_q("t2_dat");
    chk("t2_ok", n_ok, NCH);  chk("t2_fd", n_fd, 1);  chk("t2_err", n_err, 0);

    // Block 3 trailer wrong, relock from HUNT on ch 4 trailer
    clr();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < BL-1; i++) begin
        ws.push_back(fw[b*BL+i]);
        eq.push_back({5'(b), 10'(i), fw[b*BL+i]});
      end
      ws.push_back(b == 3 ? 32'h0004_0AFA : trl(b));
    end
    play(1'b0, 1'b1);
    idle(1);
    chk("t3_unlock", olocked, 0);  chk("t3_cnt", oerr_cnt, 1);
    ws.delete();
    for (int i = 0; i < BL-1; i++) ws.push_back(rnd_dat());
    ws.push_back(32'h0004_0AFA);
    for (int i = 0; i < BL-1; i++) begin
      w = rnd_dat();
      ws.push_back(w);
      eq.push_back({5'd5, 10'(i), w});
    end
    ws.push_back(trl(5));
    play(1'b0, 1'b0);
    idle(3);
    cmp_q("t3_dat");
    chk("t3_ok", n_ok, 4);  chk("t3_err", n_err, 1);  chk("t3_fd", n_fd, 0);
    chk("t3_relock", olocked, 1);  chk("t3_cnt_end", oerr_cnt, 1);

    // Async reset at word 500 of block 2, words ignored until istart
    clr();
    for (int k = 0; k < 2*BL + 500; k++) ws.push_back(fw[k]);
    play(1'b0, 1'b1);
    @(posedge clk); #1; ivalid = 1'b0; rst_n = 1'b0; #1;
    chk("t4_rst_lock", olocked, 0);  chk("t4_rst_cnt", oerr_cnt, 0);
    chk("t4_rst_out", {ovalid, ochan, oidx, odata}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clr();
    for (int i = 0; i < 5; i++) ws.push_back(rnd_dat());
    ws.push_back(trl(0));
    for (int i = 0; i < 5; i++) ws.push_back(rnd_dat());
    play(1'b0, 1'b0);
    idle(2);
    chk("t4_idle_dat", q_dat.size(), 0);  chk("t4_idle_ok", n_ok, 0);
    chk("t4_idle_lock", olocked, 0);
    clr();
    for (int i = 0; i < BL; i++) begin
      ws.push_back(fw[i]);
      if (i != BL-1) eq.push_back({5'd0, 10'(i), fw[i]});
    end
    play(1'b0, 1'b1);
    idle(3);
    cmp_q("t4_dat");
    chk("t4_ok", n_ok, 1);

    // HUNT ignores ch 17 trailer, relocks on ch 16 with exp_ch 0
    clr();
    for (int i = 0; i < BL-1; i++) begin
      ws.push_back(fw[i]);
      eq.push_back({5'd0, 10'(i), fw[i]});
    end
    ws.push_back(32'h0000_0AFB);
    play(1'b0, 1'b1);
    idle(1);
    chk("t5_unlock", olocked, 0);  chk("t5_cnt", oerr_cnt, 1);
    ws.delete();
    ws.push_back(32'h0011_0AFA);
    play(1'b0, 1'b0);
    idle(1);
    chk("t5_ch17_ignored", olocked, 0);
    ws.delete();
    for (int i = 0; i < 20; i++) ws.push_back(rnd_dat());
    ws.push_back(32'h0010_0AFA);
    play(1'b0, 1'b0);
    idle(1);
    chk("t5_ch16_lock", olocked, 1);
    ws.delete();
    for (int i = 0; i < BL-1; i++) begin
      w = rnd_dat();
      ws.push_back(w);
      eq.push_back({5'd0, 10'(i), w});
    end
    ws.push_back(trl(0));
    play(1'b0, 1'b0);
    idle(3);
    cmp_q("t5_dat");
    chk("t5_ok", n_ok, 1);  chk("t5_err", n_err, 1);  chk("t5_fd", n_fd, 0);

    // IQ capture: unpack, sign-extension errors, done on word IQN, then idle
    clr();
    exp_errs = 0;
    for (int k = 0; k < IQN; k++) begin
      if (k == 0) w = 32'hFFF8_0007;
      else if (k == 1) w = 32'h0800_0000;
      else if (k % 2 == 0) w = {16'(int'($urandom_range(4095)) - 2048), 16'(int'($urandom_range(4095)) - 2048)};
      else w = $urandom;
      ws.push_back(w);
      eiq.push_back({w[27:16], w[11:0]});
      if (!(in_rng(w[31:16]) && in_rng(w[15:0]))) begin exp_errs++; eep.push_back(k + 1); end
    end
    play(1'b1, 1'b1);
    ws.delete();
    for (int i = 0; i < 5; i++) ws.push_back($urandom);
    play(1'b0, 1'b0);
    idle(3);
    chk("t6_first", q_iq.size() > 0 ? q_iq[0] : 24'h0, 24'hFF8007);
    chk("t6_len", q_iq.size(), IQN);
    for (int k = 0; k < IQN && k < q_iq.size(); k++) chk("t6_iq", q_iq[k], eiq[k]);
    chk("t6_ep_len", q_ep.size(), eep.size());
    for (int k = 0; k < eep.size() && k < q_ep.size(); k++) chk("t6_ep", q_ep[k], eep[k]);
    chk("t6_fd", n_fd, 1);  chk("t6_fd_at", fd_at_iq, IQN);
    chk("t6_dat", q_dat.size(), 0);  chk("t6_lock", olocked, 0);
    chk("t6_cnt", oerr_cnt, 1 + exp_errs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
